// File: rtl/tcdm_bank_responder.sv
// TCDM bank responder: plain reads/writes, AMOs and LR/SC against one SRAM bank.
// Reads answer one cycle after accept; AMO/SC-hit hold off requests for one extra cycle; response buffer is credit-guarded.
module tcdm_bank_responder #(
    parameter int unsigned DataWidth        = 32,
    parameter int unsigned AddrWidth        = 32,
    parameter int unsigned TCDMAddrMemWidth = 8,
    parameter int unsigned IniAddrWidth     = 4,
    parameter int unsigned CoreIdWidth      = 4,
    parameter int unsigned MetaIdWidth      = 4,
    parameter int unsigned RespDepth        = 2,
    localparam int unsigned BeWidth      = DataWidth / 8,
    localparam int unsigned PayloadWidth = MetaIdWidth + CoreIdWidth + 4 + DataWidth,
    localparam int unsigned ReqWidth     = PayloadWidth + 1 + BeWidth + AddrWidth + IniAddrWidth,
    localparam int unsigned RespWidth    = PayloadWidth + IniAddrWidth
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [ReqWidth-1:0]         req_i,
    output logic                        resp_valid_o,
    input  logic                        resp_ready_i,
    output logic [RespWidth-1:0]        resp_o,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [TCDMAddrMemWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0]        mem_wdata_o,
    output logic [BeWidth-1:0]          mem_be_o,
    input  logic [DataWidth-1:0]        mem_rdata_i
);

    localparam int unsigned CreditWidth = $clog2(RespDepth + 1);
    localparam int unsigned PtrWidth    = $clog2(RespDepth);

    localparam logic [3:0] AmoNone = 4'h0;
    localparam logic [3:0] AmoSwap = 4'h1;
    localparam logic [3:0] AmoAdd  = 4'h2;
    localparam logic [3:0] AmoAnd  = 4'h3;
    localparam logic [3:0] AmoOr   = 4'h4;
    localparam logic [3:0] AmoXor  = 4'h5;
    localparam logic [3:0] AmoMax  = 4'h6;
    localparam logic [3:0] AmoMaxu = 4'h7;
    localparam logic [3:0] AmoMin  = 4'h8;
    localparam logic [3:0] AmoMinu = 4'h9;
    localparam logic [3:0] AmoLr   = 4'hA;
    localparam logic [3:0] AmoSc   = 4'hB;

    typedef struct packed {
        logic [MetaIdWidth-1:0] meta_id;
        logic [CoreIdWidth-1:0] core_id;
        logic [3:0]             amo;
        logic [DataWidth-1:0]   data;
    } payload_t;

    typedef struct packed {
        payload_t                wdata;
        logic                    wen;
        logic [BeWidth-1:0]      be;
        logic [AddrWidth-1:0]    tgt_addr;
        logic [IniAddrWidth-1:0] ini_addr;
    } tcdm_slave_req_t;

    typedef struct packed {
        payload_t                rdata;
        logic [IniAddrWidth-1:0] ini_addr;
    } tcdm_slave_resp_t;

    typedef enum logic {IDLE, AMO_WB} state_e;

    tcdm_slave_req_t  req;
    tcdm_slave_resp_t push_dat;
    state_e           state_q, state_d;

    logic                        init_q;
    logic [3:0]                  amo_op;
    logic                        is_write, is_lr, is_sc, is_amo, sc_match, accept;
    logic [TCDMAddrMemWidth-1:0] req_addr;
    logic [CreditWidth-1:0]      credit_q;
    logic                        consume, pop;

    logic                        wb_sc_q;
    logic [3:0]                  wb_op_q;
    logic [TCDMAddrMemWidth-1:0] wb_addr_q;
    logic [DataWidth-1:0]        wb_data_q;
    logic [BeWidth-1:0]          wb_be_q;
    logic [DataWidth-1:0]        amo_result;

    logic                        pend_vld_q, pend_use_mem_q, pend_sc_fail_q;
    logic [MetaIdWidth-1:0]      pend_meta_q;
    logic [CoreIdWidth-1:0]      pend_core_q;
    logic [3:0]                  pend_amo_q;
    logic [IniAddrWidth-1:0]     pend_ini_q;

    logic                        res_vld_q;
    logic [TCDMAddrMemWidth-1:0] res_addr_q;
    logic [CoreIdWidth-1:0]      res_core_q;
    logic [IniAddrWidth-1:0]     res_ini_q;

    tcdm_slave_resp_t            buf_q [RespDepth];
    logic [PtrWidth-1:0]         rd_ptr_q, wr_ptr_q;
    logic [CreditWidth-1:0]      cnt_q;
    logic                        buf_empty, store, deq;

    logic unused_addr_bits;

    assign req              = req_i;
    assign req_addr         = req.tgt_addr[TCDMAddrMemWidth-1:0];
    assign unused_addr_bits = ^req.tgt_addr[AddrWidth-1:TCDMAddrMemWidth];

    // Unknown AMO codes behave exactly like a plain access.
    assign amo_op   = (req.wdata.amo <= AmoSc) ? req.wdata.amo : AmoNone;
    assign is_write = (amo_op == AmoNone) && req.wen;
    assign is_lr    = (amo_op == AmoLr);
    assign is_sc    = (amo_op == AmoSc);
    assign is_amo   = (amo_op != AmoNone) && !is_lr && !is_sc;
    assign sc_match = res_vld_q && (res_addr_q == req_addr) &&
                      (res_core_q == req.wdata.core_id) && (res_ini_q == req.ini_addr);

    assign req_ready_o = init_q && (state_q == IDLE) && (is_write || (credit_q != '0));
    assign accept      = req_valid_i && req_ready_o;
    assign consume     = accept && !is_write;
    assign pop         = resp_valid_o && resp_ready_i;

    always_comb begin
        amo_result = wb_data_q;
        case (wb_op_q)
            AmoSwap: amo_result = wb_data_q;
            AmoAdd:  amo_result = mem_rdata_i + wb_data_q;
            AmoAnd:  amo_result = mem_rdata_i & wb_data_q;
            AmoOr:   amo_result = mem_rdata_i | wb_data_q;
            AmoXor:  amo_result = mem_rdata_i ^ wb_data_q;
            AmoMax:  amo_result = ($signed(mem_rdata_i) > $signed(wb_data_q)) ? mem_rdata_i : wb_data_q;
            AmoMaxu: amo_result = (mem_rdata_i > wb_data_q) ? mem_rdata_i : wb_data_q;
            AmoMin:  amo_result = ($signed(mem_rdata_i) < $signed(wb_data_q)) ? mem_rdata_i : wb_data_q;
            AmoMinu: amo_result = (mem_rdata_i < wb_data_q) ? mem_rdata_i : wb_data_q;
            default: amo_result = wb_data_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = req_addr;
        mem_wdata_o = req.wdata.data;
        mem_be_o    = req.be;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_amo || (is_sc && sc_match)) state_d = AMO_WB;
                    // SC never touches memory at accept: hits write in AMO_WB, misses not at all.
                    if (!is_sc) begin
                        mem_req_o = 1'b1;
                        mem_we_o  = is_write;
                    end
                end
            end
            AMO_WB: begin
                state_d     = IDLE;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = wb_addr_q;
                mem_wdata_o = wb_sc_q ? wb_data_q : amo_result;
                mem_be_o    = wb_sc_q ? wb_be_q : '1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            init_q   <= 1'b0;
            credit_q <= CreditWidth'(RespDepth);
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            if (consume && !pop)      credit_q <= credit_q - 1'b1;
            else if (!consume && pop) credit_q <= credit_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_vld_q     <= 1'b0;
            pend_use_mem_q <= 1'b0;
            pend_sc_fail_q <= 1'b0;
            pend_meta_q    <= '0;
            pend_core_q    <= '0;
            pend_amo_q     <= '0;
            pend_ini_q     <= '0;
            wb_sc_q        <= 1'b0;
            wb_op_q        <= AmoNone;
            wb_addr_q      <= '0;
            wb_data_q      <= '0;
            wb_be_q        <= '0;
        end else begin
            pend_vld_q <= consume;
            if (accept) begin
                pend_use_mem_q <= !is_sc;
                pend_sc_fail_q <= !sc_match;
                pend_meta_q    <= req.wdata.meta_id;
                pend_core_q    <= req.wdata.core_id;
                pend_amo_q     <= req.wdata.amo;
                pend_ini_q     <= req.ini_addr;
                wb_sc_q        <= is_sc;
                wb_op_q        <= amo_op;
                wb_addr_q      <= req_addr;
                wb_data_q      <= req.wdata.data;
                wb_be_q        <= req.be;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_vld_q  <= 1'b0;
            res_addr_q <= '0;
            res_core_q <= '0;
            res_ini_q  <= '0;
        end else if (accept && is_lr) begin
            res_vld_q  <= 1'b1;
            res_addr_q <= req_addr;
            res_core_q <= req.wdata.core_id;
            res_ini_q  <= req.ini_addr;
        end else if (accept && is_sc) begin
            res_vld_q <= 1'b0;
        end else if (accept && is_write && (req_addr == res_addr_q)) begin
            res_vld_q <= 1'b0;
        end else if ((state_q == AMO_WB) && !wb_sc_q && (wb_addr_q == res_addr_q)) begin
            res_vld_q <= 1'b0;
        end
    end

    always_comb begin
        push_dat               = '0;
        push_dat.rdata.meta_id = pend_meta_q;
        push_dat.rdata.core_id = pend_core_q;
        push_dat.rdata.amo     = pend_amo_q;
        push_dat.rdata.data    = pend_use_mem_q ? mem_rdata_i : DataWidth'(pend_sc_fail_q);
        push_dat.ini_addr      = pend_ini_q;
    end

    // Empty buffer is bypassed so a response can leave the cycle it is produced.
    assign buf_empty    = (cnt_q == '0);
    assign resp_valid_o = !buf_empty || pend_vld_q;
    assign resp_o       = buf_empty ? push_dat : buf_q[rd_ptr_q];
    assign store        = pend_vld_q && !(buf_empty && resp_ready_i);
    assign deq          = !buf_empty && resp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (store) wr_ptr_q <= (wr_ptr_q == PtrWidth'(RespDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (deq)   rd_ptr_q <= (rd_ptr_q == PtrWidth'(RespDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (store && !deq)      cnt_q <= cnt_q + 1'b1;
            else if (!store && deq) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (store) buf_q[wr_ptr_q] <= push_dat;
    end

    buf_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(store && !deq && (cnt_q == CreditWidth'(RespDepth))));

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Directed bench for tcdm_bank_responder with an SRAM model and a response scoreboard.
module tb_tcdm_bank_responder;

    localparam logic [3:0] AMO_NONE = 4'h0;
    localparam logic [3:0] AMO_ADD  = 4'h2;
    localparam logic [3:0] AMO_XOR  = 4'h5;
    localparam logic [3:0] AMO_MIN  = 4'h8;
    localparam logic [3:0] AMO_MINU = 4'h9;
    localparam logic [3:0] AMO_LR   = 4'hA;
    localparam logic [3:0] AMO_SC   = 4'hB;

    typedef struct packed {
        logic [3:0]  meta_id;
        logic [3:0]  core_id;
        logic [3:0]  amo;
        logic [31:0] data;
    } payload_t;

    typedef struct packed {
        payload_t    wdata;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] tgt_addr;
        logic [3:0]  ini_addr;
    } req_t;

    typedef struct packed {
        payload_t   rdata;
        logic [3:0] ini_addr;
    } resp_t;

    logic        clk_i, rst_ni, req_valid_i, req_ready_o, resp_valid_o, resp_ready_i;
    req_t        req;
    resp_t       resp;
    logic        mem_req_o, mem_we_o;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;

    logic [31:0] sram [0:255];
    resp_t       exp_q [$];
    int          n_assert = 0;
    int          n_fail   = 0;
    bit          stall_q  = 0;
    resp_t       prev_resp;

    tcdm_bank_responder dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_i       (req),
        .resp_valid_o(resp_valid_o),
        .resp_ready_i(resp_ready_i),
        .resp_o      (resp),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_rdata_i (mem_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata_i <= sram[mem_addr_o];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (stall_q) check("resp_stable", 64'(resp), 64'(prev_resp));
            if (resp_valid_o && resp_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 64'(exp_q.size()), 64'd1);
                end else begin
                    resp_t e;
                    e = exp_q.pop_front();
                    check("resp_data", 64'(resp.rdata.data), 64'(e.rdata.data));
                    check("resp_echo", {resp.rdata.meta_id, resp.rdata.core_id, resp.rdata.amo, resp.ini_addr},
                                       {e.rdata.meta_id, e.rdata.core_id, e.rdata.amo, e.ini_addr});
                end
            end
            stall_q   = resp_valid_o && !resp_ready_i;
            prev_resp = resp;
        end else begin
            stall_q = 0;
        end
    end

    task automatic drive(input logic wen, input logic [3:0] amo, input int addr, input logic [31:0] data,
                         input logic [3:0] be, input logic [3:0] core, input logic [3:0] meta, input logic [3:0] ini);
        req.wdata.meta_id = meta;
        req.wdata.core_id = core;
        req.wdata.amo     = amo;
        req.wdata.data    = data;
        req.wen           = wen;
        req.be            = be;
        req.tgt_addr      = 32'(addr);
        req.ini_addr      = ini;
        req_valid_i       = 1'b1;
    endtask

    // Holds the driven request until accepted; expected response is queued at the accept edge.
    task automatic wait_accept(input string tag, input bit exp_resp, input logic [31:0] exp_data);
        bit ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk_i);
            ok = req_ready_o;
            if (ok && exp_resp) begin
                resp_t e;
                e.rdata.meta_id = req.wdata.meta_id;
                e.rdata.core_id = req.wdata.core_id;
                e.rdata.amo     = req.wdata.amo;
                e.rdata.data    = exp_data;
                e.ini_addr      = req.ini_addr;
                exp_q.push_back(e);
            end
            if (ok && req.wen && req.wdata.amo == AMO_NONE)
                check({tag, "_mem_write"}, {mem_req_o, mem_we_o, mem_be_o, mem_wdata_o},
                                           {1'b1, 1'b1, req.be, req.wdata.data});
            @(posedge clk_i);
        end
        #1 req_valid_i = 1'b0;
        check({tag, "_accepted"}, 64'(ok), 64'd1);
    endtask

    task automatic send(input string tag, input logic wen, input logic [3:0] amo, input int addr,
                        input logic [31:0] data, input logic [3:0] be, input logic [3:0] core,
                        input logic [3:0] meta, input logic [3:0] ini, input bit exp_resp, input logic [31:0] exp_data);
        drive(wen, amo, addr, data, be, core, meta, ini);
        wait_accept(tag, exp_resp, exp_data);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk_i);
        #1 check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        resp_ready_i = 1'b1;
        req          = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ready", 64'(req_ready_o), 64'd0);
        check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        check("rst_mem", {mem_req_o, mem_we_o}, 2'b00);
        rst_ni = 1'b1;
        #1 check("ready_before_first_clk", 64'(req_ready_o), 64'd0);
        @(posedge clk_i);
        #1 check("ready_after_first_clk", 64'(req_ready_o), 64'd1);

        send("wr5", 1, AMO_NONE, 5, 32'hDEADBEEF, 4'hF, 4'd0, 4'd3, 4'd2, 0, 0);
        send("rd5", 0, AMO_NONE, 5, 32'h0, 4'hF, 4'd1, 4'd9, 4'd6, 1, 32'hDEADBEEF);
        drain("drain_rd5");

        send("wr3", 1, AMO_NONE, 3, 32'hFFFFFFFF, 4'hF, 4'd0, 4'd1, 4'd1, 0, 0);
        send("add3", 0, AMO_ADD, 3, 32'h1, 4'hF, 4'd2, 4'd4, 4'd5, 1, 32'hFFFFFFFF);
        @(negedge clk_i);
        check("ready_in_amo_wb", 64'(req_ready_o), 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("ready_after_amo_wb", 64'(req_ready_o), 64'd1);
        @(posedge clk_i);
        #1 send("rd3", 0, AMO_NONE, 3, 32'h0, 4'hF, 4'd2, 4'd5, 4'd5, 1, 32'h00000000);

        send("wr4a", 1, AMO_NONE, 4, 32'h00000001, 4'hF, 4'd0, 4'd0, 4'd0, 0, 0);
        send("min4", 0, AMO_MIN, 4, 32'h80000000, 4'hF, 4'd3, 4'd6, 4'd7, 1, 32'h00000001);
        send("rd4_min", 0, AMO_NONE, 4, 32'h0, 4'hF, 4'd3, 4'd7, 4'd7, 1, 32'h80000000);
        send("wr4b", 1, AMO_NONE, 4, 32'h00000001, 4'hF, 4'd0, 4'd0, 4'd0, 0, 0);
        send("minu4", 0, AMO_MINU, 4, 32'h80000000, 4'hF, 4'd3, 4'd8, 4'd7, 1, 32'h00000001);
        send("rd4_minu", 0, AMO_NONE, 4, 32'h0, 4'hF, 4'd3, 4'd9, 4'd7, 1, 32'h00000001);
        send("xor4", 0, AMO_XOR, 4, 32'hFFFF0000, 4'hF, 4'd3, 4'd10, 4'd7, 1, 32'h00000001);
        send("rd4_xor", 0, AMO_NONE, 4, 32'h0, 4'hF, 4'd3, 4'd11, 4'd7, 1, 32'hFFFF0001);
        drain("drain_amo");

        send("wr7", 1, AMO_NONE, 7, 32'h11111111, 4'hF, 4'd0, 4'd0, 4'd1, 0, 0);
        send("lr7a", 0, AMO_LR, 7, 32'h0, 4'hF, 4'd0, 4'd12, 4'd1, 1, 32'h11111111);
        send("sc7_hit", 1, AMO_SC, 7, 32'h22222222, 4'hF, 4'd0, 4'd13, 4'd1, 1, 32'h0);
        send("rd7_hit", 0, AMO_NONE, 7, 32'h0, 4'hF, 4'd0, 4'd14, 4'd1, 1, 32'h22222222);
        send("lr7b", 0, AMO_LR, 7, 32'h0, 4'hF, 4'd0, 4'd15, 4'd1, 1, 32'h22222222);
        send("wr7_core1", 1, AMO_NONE, 7, 32'h33333333, 4'hF, 4'd1, 4'd0, 4'd2, 0, 0);
        send("sc7_miss", 1, AMO_SC, 7, 32'h44444444, 4'hF, 4'd0, 4'd1, 4'd1, 1, 32'h1);
        @(negedge clk_i);
        check("sc_miss_no_mem", 64'(mem_req_o), 64'd0);
        @(posedge clk_i);
        #1 send("rd7_miss", 0, AMO_NONE, 7, 32'h0, 4'hF, 4'd0, 4'd2, 4'd1, 1, 32'h33333333);
        drain("drain_lrsc");

        send("wr10", 1, AMO_NONE, 10, 32'hA0A0A0A0, 4'hF, 4'd0, 4'd0, 4'd0, 0, 0);
        send("wr11", 1, AMO_NONE, 11, 32'hA1A1A1A1, 4'hF, 4'd0, 4'd0, 4'd0, 0, 0);
        send("wr12", 1, AMO_NONE, 12, 32'hA2A2A2A2, 4'hF, 4'd0, 4'd0, 4'd0, 0, 0);
        resp_ready_i = 1'b0;
        send("bp_rd10", 0, AMO_NONE, 10, 32'h0, 4'hF, 4'd4, 4'd1, 4'd3, 1, 32'hA0A0A0A0);
        send("bp_rd11", 0, AMO_NONE, 11, 32'h0, 4'hF, 4'd4, 4'd2, 4'd3, 1, 32'hA1A1A1A1);
        drive(0, AMO_NONE, 12, 32'h0, 4'hF, 4'd4, 4'd3, 4'd3);
        repeat (3) begin
            @(negedge clk_i);
            check("bp_ready_low", 64'(req_ready_o), 64'd0);
        end
        @(posedge clk_i);
        #1 resp_ready_i = 1'b1;
        wait_accept("bp_rd12", 1, 32'hA2A2A2A2);
        drain("drain_bp");

        send("wr8", 1, AMO_NONE, 8, 32'h00000088, 4'hF, 4'd0, 4'd0, 4'd0, 0, 0);
        send("wr9", 1, AMO_NONE, 9, 32'h00000005, 4'hF, 4'd0, 4'd0, 4'd0, 0, 0);
        send("lr8", 0, AMO_LR, 8, 32'h0, 4'hF, 4'd2, 4'd4, 4'd3, 1, 32'h00000088);
        drain("drain_pre_rst");
        send("add9_rst", 0, AMO_ADD, 9, 32'h10, 4'hF, 4'd2, 4'd5, 4'd3, 0, 0);
        rst_ni = 1'b0;
        #1 check("rst_wb_mem", {mem_req_o, mem_we_o}, 2'b00);
        check("rst_wb_resp_valid", 64'(resp_valid_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1 send("rd9_after_rst", 0, AMO_NONE, 9, 32'h0, 4'hF, 4'd2, 4'd6, 4'd3, 1, 32'h00000005);
        send("sc8_after_rst", 1, AMO_SC, 8, 32'h99, 4'hF, 4'd2, 4'd7, 4'd3, 1, 32'h1);
        send("rd8_after_sc", 0, AMO_NONE, 8, 32'h0, 4'hF, 4'd2, 4'd8, 4'd3, 1, 32'h00000088);
        drain("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
